// File: rtl/serial_carry_add_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// The master drives operands and start; the slave returns the result.
interface serial_carry_add_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             busy;
  logic             done;

  modport master (
    output start, X, Y, Cin,
    input  Sum, Cout, busy, done
  );

  modport slave (
    input  start, X, Y, Cin,
    output Sum, Cout, busy, done
  );
endinterface

// File: rtl/serial_carry_add.sv
// Bit-serial ripple-carry adder, LSB first, one carry flop.
// Sum = X + Y + Cin, reported through a start/busy/done handshake.
module serial_carry_add #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_carry_add_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-1:0] r_ys;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_n;

  assign w_s     = r_xs[0] ^ r_ys[0] ^ r_c;
  assign w_co    = (r_xs[0] & r_ys[0]) |
                   (r_xs[0] & r_c) |
                   (r_ys[0] & r_c);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_acc_n = {w_s, r_acc[WIDTH-1:1]};

  assign bus.Sum  = r_sum;
  assign bus.Cout = r_cout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_xs    <= '0;
      r_ys    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_xs    <= bus.X;
            r_ys    <= bus.Y;
            r_c     <= bus.Cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_c   <= w_co;
          r_acc <= w_acc_n;
          r_xs  <= r_xs >> 1;
          r_ys  <= r_ys >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_acc_n;
            r_cout  <= w_co;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          // The DONE edge doubles as the next accept slot: one add per WIDTH+1
          if (bus.start) begin
            r_xs    <= bus.X;
            r_ys    <= bus.Y;
            r_c     <= bus.Cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_carry_add.sv
// Directed-vector bench for serial_carry_add (WIDTH=4).
// Expected sums are hand-computed constants.
module tb_serial_carry_add;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [3:0] last_sum;
  logic       last_cout;

  serial_carry_add_if #(.WIDTH(4)) bus ();

  serial_carry_add #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_add(input string tag,
                        input logic [3:0] x,
                        input logic [3:0] y,
                        input logic ci,
                        input logic [3:0] es,
                        input logic ec);
    int lat;
    int bcnt;
    logic held;
    @(negedge clk);
    bus.X = x; bus.Y = y; bus.Cin = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; bcnt = 0; held = 1'b1;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      if (bus.Sum !== last_sum || bus.Cout !== last_cout) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_held"}, held, 1);
    chk({tag, "_sum"}, bus.Sum, es);
    chk({tag, "_cout"}, bus.Cout, ec);
    if (bus.busy) bcnt++;
    @(posedge clk); #1;
    chk({tag, "_busy5"}, bcnt, 5);
    chk({tag, "_donelo"}, bus.done, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    last_sum = es;
    last_cout = ec;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    n_vec = 0; n_err = 0;
    last_sum = 4'h0; last_cout = 1'b0;
    bus.start = 1'b0; bus.X = '0; bus.Y = '0; bus.Cin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", bus.Sum, 0);
    chk("rst_cout", bus.Cout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk); rst_n = 1'b1;

    do_add("a13p5", 4'b1101, 4'b0101, 1'b0, 4'b0010, 1'b1);
    do_add("a12p8c", 4'b1100, 4'b1000, 1'b1, 4'b0101, 1'b1);
    do_add("a5p5", 4'b0101, 4'b0101, 1'b0, 4'b1010, 1'b0);

    // Reset two edges into an operation
    @(negedge clk);
    bus.X = 4'b1111; bus.Y = 4'b1111; bus.Cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sum", bus.Sum, 0);
    chk("arst_cout", bus.Cout, 0);
    chk("arst_busy", bus.busy, 0);
    dn = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("arst_nodone", dn, 0);
    last_sum = 4'h0; last_cout = 1'b0;
    do_add("a6p3", 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0);

    do_add("ff_0_c", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
    do_add("ff_ff_c", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
    do_add("zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Start held high; operands change mid-flight
    @(negedge clk);
    bus.X = 4'b0011; bus.Y = 4'b0001; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    dn = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
      if (k == 2) bus.X = 4'b1111;
      if (k == 4) begin
        chk("hold_d1", bus.done, 1);
        chk("hold_s1", bus.Sum, 4'b0100);
        chk("hold_c1", bus.Cout, 0);
      end
      if (k == 5) begin
        chk("hold_restart", bus.busy, 1);
        bus.start = 1'b0;
      end
      if (k == 8) chk("hold_keep", bus.Sum, 4'b0100);
      if (k == 9) begin
        chk("hold_d2", bus.done, 1);
        chk("hold_s2", bus.Sum, 4'b0000);
        chk("hold_c2", bus.Cout, 1);
      end
      if (k == 10) chk("hold_idle", bus.busy, 0);
    end
    chk("hold_npulse", dn, 2);
    last_sum = 4'b0000; last_cout = 1'b1;

    do_add("trip", 4'b1000, 4'b0101, 1'b0, 4'b1101, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
